hybridcore_data_memory: RTL and testbench

Memory-side responder for the hybridcore_processor data memory interface. It completes the processor's read/write requests against a word-addressed 64-bit array with a configurable, fully pipelined read latency. It replaces the bench-driven mem_data_in stub at system level and in processor benches. It flags misaligned and out-of-range accesses and counts them.

---
 rtl/hybridcore_data_memory.sv | 89 ++++++++
 tb/tb_hybridcore_data_memory.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hybridcore_data_memory.sv
// hybridcore_data_memory: memory-side responder for the hybridcore_processor
// data port. Word-addressed 64-bit array with a fixed-latency, fully pipelined
// read path and registered illegal-access reporting.
module hybridcore_data_memory #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_data_out,
    input  logic        mem_write_enable,
    input  logic        mem_read_enable,
    output logic [63:0] mem_data_in,
    output logic        mem_data_valid,
    output logic        mem_error,
    output logic [7:0]  err_count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [63:0]             mem_array [DEPTH];
    logic [ADDR_W-1:0]       idx;
    logic                    addr_legal;
    logic                    illegal;
    logic [63:0]             rd_data;

    // Stage k of the read pipeline; the last stage doubles as the output
    // register, so it only loads when a valid result arrives and otherwise holds.
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [63:0]             pipe_dat [READ_LATENCY];

    // Address decode and the read value captured on acceptance (write-first:
    // the shared address means a same-edge write always targets the read word).
    always_comb begin
        idx        = mem_addr[ADDR_W+2:3];
        addr_legal = (mem_addr[2:0] == 3'b000) && (mem_addr[31:ADDR_W+3] == '0);
        illegal    = (mem_write_enable | mem_read_enable) & ~addr_legal;
        rd_data    = 64'h0;
        if (addr_legal) begin
            rd_data = mem_write_enable ? mem_data_out : mem_array[idx];
        end
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_write_enable && addr_legal) begin
            mem_array[idx] <= mem_data_out;
        end
    end

    // Read pipeline shift: one entry per cycle, bubbles shift through as invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_dat[k] <= 64'h0;
            end
        end else begin
            pipe_vld <= READ_LATENCY'({pipe_vld, mem_read_enable});
            for (int k = READ_LATENCY - 1; k >= 1; k--) begin
                if (pipe_vld[k-1]) begin
                    pipe_dat[k] <= pipe_dat[k-1];
                end
            end
            if (mem_read_enable) begin
                pipe_dat[0] <= rd_data;
            end
        end
    end

    // Illegal-access pulse and saturating counter; a combined read+write on one
    // bad address is a single illegal access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_error <= 1'b0;
            err_count <= 8'h00;
        end else begin
            mem_error <= illegal;
            if (illegal && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign mem_data_valid = pipe_vld[READ_LATENCY-1];
    assign mem_data_in    = pipe_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_hybridcore_data_memory.sv
// Bench for hybridcore_data_memory: two instances (latency 2 and latency 4)
// share stimulus; the latency-4 instance has its own reset.
module tb_hybridcore_data_memory;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst4;
    logic [31:0] mem_addr;
    logic [63:0] mem_data_out;
    logic        mem_write_enable;
    logic        mem_read_enable;

    logic [63:0] d2_data;
    logic        d2_valid;
    logic        d2_error;
    logic [7:0]  d2_count;
    logic [63:0] d4_data;
    logic        d4_valid;
    logic        d4_error;
    logic [7:0]  d4_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference state
    logic [63:0] mem_m [int];
    logic [63:0] exp2  [int];
    logic [63:0] exp4  [int];
    logic [63:0] last2 = 64'h0;
    logic [63:0] last4 = 64'h0;
    logic        exp_err  = 1'b0;
    logic        exp_err4 = 1'b0;
    int          cnt2 = 0;
    int          cnt4 = 0;
    logic        in_rst4 = 1'b0;

    hybridcore_data_memory #(.DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_data_in(d2_data), .mem_data_valid(d2_valid),
        .mem_error(d2_error), .err_count(d2_count)
    );

    hybridcore_data_memory #(.DEPTH(DEPTH), .READ_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst4), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_data_in(d4_data), .mem_data_valid(d4_valid),
        .mem_error(d4_error), .err_count(d4_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic is_legal(input logic [31:0] a);
        return (a % 8 == 0) && (a < DEPTH * 8);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        logic v2;
        logic v4;
        v2 = exp2.exists(cyc);
        if (v2) begin
            last2 = exp2[cyc];
            exp2.delete(cyc);
        end
        v4 = exp4.exists(cyc);
        if (v4) begin
            last4 = exp4[cyc];
            exp4.delete(cyc);
        end
        chk("l2_valid", {63'b0, d2_valid}, {63'b0, v2});
        chk("l2_data",  d2_data, last2);
        chk("l2_error", {63'b0, d2_error}, {63'b0, exp_err});
        chk("l2_count", {56'b0, d2_count}, 64'(cnt2));
        chk("l4_valid", {63'b0, d4_valid}, {63'b0, v4});
        chk("l4_data",  d4_data, last4);
        chk("l4_error", {63'b0, d4_error}, {63'b0, exp_err4});
        chk("l4_count", {56'b0, d4_count}, 64'(cnt4));
    endtask

    task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [63:0] d);
        logic        lg;
        logic [63:0] r;
        mem_write_enable = we;
        mem_read_enable  = re;
        mem_addr         = a;
        mem_data_out     = d;
        @(posedge clk);
        cyc++;
        lg = is_legal(a);
        if (re) begin
            r = !lg ? 64'h0 : (we ? d : mem_m[int'(a / 8)]);
            exp2[cyc + 1] = r;
            if (!in_rst4) exp4[cyc + 3] = r;
        end
        if (we && lg) mem_m[int'(a / 8)] = d;
        exp_err = (we || re) && !lg;
        if (exp_err && cnt2 != 255) cnt2++;
        exp_err4 = in_rst4 ? 1'b0 : exp_err;
        if (exp_err4 && cnt4 != 255) cnt4++;
        #1;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        rst = 1'b0;
        rst4 = 1'b0;
        mem_addr = 32'h0;
        mem_data_out = 64'h0;
        mem_write_enable = 1'b0;
        mem_read_enable = 1'b0;

        // Reset state
        #7;
        chk("rst_l2_valid", {63'b0, d2_valid}, 64'h0);
        chk("rst_l2_data",  d2_data, 64'h0);
        chk("rst_l2_error", {63'b0, d2_error}, 64'h0);
        chk("rst_l2_count", {56'b0, d2_count}, 64'h0);
        chk("rst_l4_valid", {63'b0, d4_valid}, 64'h0);
        chk("rst_l4_count", {56'b0, d4_count}, 64'h0);
        #5;
        rst = 1'b1;
        rst4 = 1'b1;
        idle(2);

        // Write then read, latency 2
        step(1'b1, 1'b0, 32'h28, 64'h8);
        step(1'b0, 1'b1, 32'h28, 64'h0);
        step(1'b0, 1'b0, 32'h0, 64'h0);
        chk("t1_valid", {63'b0, d2_valid}, 64'h1);
        chk("t1_data",  d2_data, 64'h8);
        chk("t1_error", {63'b0, d2_error}, 64'h0);
        idle(4);

        // Back-to-back reads
        step(1'b1, 1'b0, 32'h30, 64'hF);
        step(1'b1, 1'b0, 32'h38, 64'h2);
        step(1'b0, 1'b1, 32'h28, 64'h0);
        step(1'b0, 1'b1, 32'h30, 64'h0);
        chk("t2_first", d2_data, 64'h8);
        step(1'b0, 1'b1, 32'h38, 64'h0);
        chk("t2_second", d2_data, 64'hF);
        step(1'b0, 1'b0, 32'h0, 64'h0);
        chk("t2_third", d2_data, 64'h2);
        step(1'b0, 1'b0, 32'h0, 64'h0);
        chk("t2_after", {63'b0, d2_valid}, 64'h0);
        idle(3);

        // Same-edge read and write, then an overwrite while in flight
        step(1'b1, 1'b1, 32'h30, 64'h0000_0000_4040_0000);
        step(1'b1, 1'b0, 32'h30, 64'h1);
        chk("t3_rd", d2_data, 64'h0000_0000_4040_0000);
        idle(3);
        step(1'b0, 1'b1, 32'h30, 64'h0);
        idle(4);

        // Illegal accesses
        step(1'b1, 1'b0, 32'h2C, 64'hDEAD);
        chk("t4_err_pulse", {63'b0, d2_error}, 64'h1);
        chk("t4_cnt1", {56'b0, d2_count}, 64'h1);
        step(1'b0, 1'b1, 32'h28, 64'h0);
        chk("t4_err_clear", {63'b0, d2_error}, 64'h0);
        step(1'b0, 1'b1, 32'h800, 64'h0);
        chk("t4_word5", d2_data, 64'h8);
        chk("t4_cnt2", {56'b0, d2_count}, 64'h2);
        step(1'b0, 1'b0, 32'h0, 64'h0);
        chk("t4_oor_valid", {63'b0, d2_valid}, 64'h1);
        chk("t4_oor_data", d2_data, 64'h0);
        idle(3);

        // Randomized traffic against the reference model
        for (int w = 0; w < 32; w++) step(1'b1, 1'b0, 32'(w * 8), {$urandom, $urandom});
        step(1'b1, 1'b0, 32'(255 * 8), {$urandom, $urandom});
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, 31) * 8);
            else if (sel == 7) a = 32'($urandom_range(0, 255) * 8 + $urandom_range(1, 7));
            else if (sel == 8) a = ($urandom | 32'h800) & 32'hFFFF_FFF8;
            else               a = $urandom | 32'h801;
            if (sel == 0) a = 32'(255 * 8);
            step(1'($urandom % 2), 1'($urandom % 2), a, {$urandom, $urandom});
        end
        idle(5);

        // Saturation
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 32'h2C, 64'hDEAD);
        chk("t5_sat_l2", {56'b0, d2_count}, 64'hFF);
        chk("t5_sat_l4", {56'b0, d4_count}, 64'hFF);
        idle(2);
        chk("t5_hold", {56'b0, d2_count}, 64'hFF);

        // Reset mid-flight on the latency-4 instance
        step(1'b0, 1'b1, 32'h28, 64'h0);
        step(1'b0, 1'b0, 32'h0, 64'h0);
        #2;
        rst4 = 1'b0;
        in_rst4 = 1'b1;
        exp4.delete();
        last4 = 64'h0;
        cnt4 = 0;
        exp_err4 = 1'b0;
        #1;
        chk("t6_async_valid", {63'b0, d4_valid}, 64'h0);
        chk("t6_async_data", d4_data, 64'h0);
        chk("t6_async_count", {56'b0, d4_count}, 64'h0);
        idle(3);
        #2;
        rst4 = 1'b1;
        in_rst4 = 1'b0;
        idle(6);
        step(1'b0, 1'b1, 32'h28, 64'h0);
        step(1'b0, 1'b1, 32'h38, 64'h0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
